// File: rtl/instr_sequencer_if.sv
// Handshake and bus bundle between instr_sequencer (master) and the
// memory / register-file / PC datapath (slave).
`timescale 1ns/1ps
interface instr_sequencer_if;
  logic [7:0]  data_i;
  logic        mem_ready_i;
  logic        mem_rd_o;
  logic [2:0]  reg16_sel_o;
  logic [2:0]  reg8_sel_o;
  logic        reg_read_o;
  logic        reg_write_o;
  logic        tmp_oe_o;
  logic [7:0]  bus_o;
  logic        pc_inc_o;
  logic        pc_load_o;
  logic [15:0] pc_addr_o;
  logic        instr_done_o;
  logic        illegal_o;
  logic        halted_o;
  logic        bus_err_o;

  modport master (
    input  data_i, mem_ready_i,
    output mem_rd_o, reg16_sel_o, reg8_sel_o, reg_read_o, reg_write_o,
           tmp_oe_o, bus_o, pc_inc_o, pc_load_o, pc_addr_o,
           instr_done_o, illegal_o, halted_o, bus_err_o
  );

  modport slave (
    output data_i, mem_ready_i,
    input  mem_rd_o, reg16_sel_o, reg8_sel_o, reg_read_o, reg_write_o,
           tmp_oe_o, bus_o, pc_inc_o, pc_load_o, pc_addr_o,
           instr_done_o, illegal_o, halted_o, bus_err_o
  );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller for the 8080 datapath (NOP, MOV r,r, MVI, JMP, HLT).
// Optional memory-wait timeout enabled by defining SEQ_TIMEOUT_EN.
`timescale 1ns/1ps
module instr_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic          clk50M_i,
  input  logic          rst_ni,
  instr_sequencer_if.master sif
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MOV_RD, S_MOV_WR, S_IMM_RD, S_IMM_WR,
    S_JLO, S_JHI, S_JLOAD, S_HALT
  } state_t;

  state_t     state, state_n;
  logic [7:0] ir, tmp, lo, hi;
  logic [2:0] ddd, sss;
  logic       mem_state, rd_done, timeout;

  assign ddd       = ir[5:3];
  assign sss       = ir[2:0];
  assign mem_state = (state == S_FETCH) || (state == S_IMM_RD) ||
                     (state == S_JLO)   || (state == S_JHI);
  assign rd_done   = mem_state & sif.mem_ready_i;

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Counter restarts whenever the state changes, so each read gets a fresh budget.
  always_ff @(posedge clk50M_i) begin
    if (!rst_ni) begin
      wait_cnt <= '0;
    end else if (state_n != state) begin
      wait_cnt <= '0;
    end else if (mem_state && !sif.mem_ready_i) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Ready on the limit cycle wins because timeout requires ready low.
  assign timeout = mem_state & ~sif.mem_ready_i &
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge clk50M_i) begin
    if (!rst_ni) begin
      state <= S_IDLE;
      ir    <= '0;
      tmp   <= '0;
      lo    <= '0;
      hi    <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_FETCH:  if (rd_done) ir  <= sif.data_i;
        S_MOV_RD: tmp <= sif.data_i;
        S_IMM_RD: if (rd_done) tmp <= sif.data_i;
        S_JLO:    if (rd_done) lo  <= sif.data_i;
        S_JHI:    if (rd_done) hi  <= sif.data_i;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n          = state;
    sif.mem_rd_o     = 1'b0;
    sif.reg16_sel_o  = 3'b100;
    sif.reg8_sel_o   = 3'b000;
    sif.reg_read_o   = 1'b0;
    sif.reg_write_o  = 1'b0;
    sif.tmp_oe_o     = 1'b0;
    sif.bus_o        = '0;
    sif.pc_inc_o     = 1'b0;
    sif.pc_load_o    = 1'b0;
    sif.pc_addr_o    = '0;
    sif.instr_done_o = 1'b0;
    sif.illegal_o    = 1'b0;
    sif.halted_o     = 1'b0;
    sif.bus_err_o    = timeout;

    if (mem_state) begin
      sif.mem_rd_o = 1'b1;
      sif.pc_inc_o = sif.mem_ready_i;
    end

    case (state)
      S_IDLE:   state_n = S_FETCH;
      S_FETCH:  if (timeout) state_n = S_HALT; else if (rd_done) state_n = S_DECODE;
      S_IMM_RD: if (timeout) state_n = S_HALT; else if (rd_done) state_n = S_IMM_WR;
      S_JLO:    if (timeout) state_n = S_HALT; else if (rd_done) state_n = S_JHI;
      S_JHI:    if (timeout) state_n = S_HALT; else if (rd_done) state_n = S_JLOAD;
      S_DECODE: begin
        if (ir == 8'h00) begin
          sif.instr_done_o = 1'b1;
          state_n          = S_FETCH;
        end else if (ir == 8'h76) begin
          state_n = S_HALT;
        end else if (ir[7:6] == 2'b01 && ddd != 3'b110 && sss != 3'b110) begin
          state_n = S_MOV_RD;
        end else if (ir[7:6] == 2'b00 && sss == 3'b110 && ddd != 3'b110) begin
          state_n = S_IMM_RD;
        end else if (ir == 8'hC3) begin
          state_n = S_JLO;
        end else begin
          sif.illegal_o    = 1'b1;
          sif.instr_done_o = 1'b1;
          state_n          = S_FETCH;
        end
      end
      S_MOV_RD: begin
        sif.reg_read_o = 1'b1;
        sif.reg8_sel_o = sss;
        state_n        = S_MOV_WR;
      end
      S_MOV_WR, S_IMM_WR: begin
        sif.tmp_oe_o     = 1'b1;
        sif.bus_o        = tmp;
        sif.reg_write_o  = 1'b1;
        sif.reg8_sel_o   = ddd;
        sif.instr_done_o = 1'b1;
        state_n          = S_FETCH;
      end
      S_JLOAD: begin
        sif.pc_load_o    = 1'b1;
        sif.pc_addr_o    = {hi, lo};
        sif.instr_done_o = 1'b1;
        state_n          = S_FETCH;
      end
      S_HALT:   sif.halted_o = 1'b1;
      default:  state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: emulates memory, register file and PC around the DUT
// and checks each retired instruction against an ISA-level model.
`timescale 1ns/1ps
module tb_instr_sequencer;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_sequencer_if sif();

  instr_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk50M_i (clk),
    .rst_ni   (rst_n),
    .sif      (sif)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [0:65535];
  logic [7:0]  dp_regs [8];
  logic [15:0] dp_pc;
  logic [7:0]  m_regs [8];
  logic [15:0] m_pc;
  int unsigned n_inc, n_rd, n_wr, n_load, n_done, n_ill, n_memrd, n_err, viol;
  int unsigned wq [$];
  bit stall = 1'b0;

  // Datapath emulation driven by the DUT strobes, plus strobe counters.
  always @(posedge clk) begin
    if (!rst_n) begin
      dp_pc <= '0;
      for (int i = 0; i < 8; i++) dp_regs[i] <= 8'(17 * i + 3);
    end else begin
      if (sif.pc_load_o) dp_pc <= sif.pc_addr_o;
      else if (sif.pc_inc_o) dp_pc <= dp_pc + 16'd1;
      if (sif.reg_write_o) dp_regs[sif.reg8_sel_o] <= sif.bus_o;
    end
    if (sif.pc_inc_o)     n_inc   <= n_inc + 1;
    if (sif.reg_read_o)   n_rd    <= n_rd + 1;
    if (sif.reg_write_o)  n_wr    <= n_wr + 1;
    if (sif.pc_load_o)    n_load  <= n_load + 1;
    if (sif.instr_done_o) n_done  <= n_done + 1;
    if (sif.illegal_o)    n_ill   <= n_ill + 1;
    if (sif.mem_rd_o)     n_memrd <= n_memrd + 1;
    if (sif.bus_err_o)    n_err   <= n_err + 1;
    if ((sif.reg_read_o && sif.tmp_oe_o) || (sif.pc_inc_o && sif.pc_load_o) ||
        (sif.reg_write_o != sif.tmp_oe_o) || (sif.reg16_sel_o != 3'b100) ||
        (sif.pc_inc_o && !sif.mem_ready_i) ||
        (!sif.reg_read_o && !sif.reg_write_o && sif.reg8_sel_o != 3'b000))
      viol <= viol + 1;
  end

  // Memory / register-file responder with per-read wait counts taken from wq.
  initial begin
    int unsigned wl;
    bit fresh;
    wl = 0;
    fresh = 1'b1;
    sif.data_i = '0;
    sif.mem_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      sif.data_i = sif.reg_read_o ? dp_regs[sif.reg8_sel_o] : mem[dp_pc];
      if (!rst_n || !sif.mem_rd_o) begin
        sif.mem_ready_i = 1'b0;
        fresh = 1'b1;
      end else if (stall) begin
        sif.mem_ready_i = 1'b0;
      end else begin
        if (fresh) begin
          wl = (wq.size() > 0) ? wq.pop_front() : 0;
          fresh = 1'b0;
        end
        if (wl > 0) begin
          sif.mem_ready_i = 1'b0;
          wl--;
        end else begin
          sif.mem_ready_i = 1'b1;
          fresh = 1'b1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outvec();
    return 64'({sif.mem_rd_o, sif.reg8_sel_o, sif.reg_read_o, sif.reg_write_o,
                sif.tmp_oe_o, sif.bus_o, sif.pc_inc_o, sif.pc_load_o, sif.pc_addr_o,
                sif.instr_done_o, sif.illegal_o, sif.halted_o, sif.bus_err_o});
  endfunction

  function automatic bit is_legal(input logic [7:0] op);
    logic [2:0] d, s;
    d = op[5:3];
    s = op[2:0];
    return (op == 8'h00) || (op == 8'hC3) || (op == 8'h76) ||
           (op[7:6] == 2'b01 && d != 3'd6 && s != 3'd6) ||
           (op[7:6] == 2'b00 && s == 3'd6 && d != 3'd6);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    stall = 1'b0;
    wq.delete();
    repeat (2) @(negedge clk);
    check("reset_outputs", outvec(), 64'd0);
    check("reset_reg16_sel", 64'(sif.reg16_sel_o), 64'd4);
    m_pc = '0;
    for (int i = 0; i < 8; i++) m_regs[i] = 8'(17 * i + 3);
    rst_n = 1'b1;
    check("idle_mem_rd", 64'(sif.mem_rd_o), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Runs one non-HLT instruction; expectations come from the ISA semantics.
  task automatic exec(input logic [7:0] op, input logic [7:0] b1, input logic [7:0] b2,
                      input int unsigned w0, input int unsigned w1, input int unsigned w2);
    int unsigned len, base, wsum, cyc, e_rd, e_wr, e_load, e_ill;
    int unsigned s_inc, s_rd, s_wr, s_load, s_done, s_ill, s_viol;
    bit chk_cyc;
    logic [2:0] d, s;
    logic [15:0] a;
    logic [63:0] pm, pd;
    d = op[5:3];
    s = op[2:0];
    e_rd = 0; e_wr = 0; e_load = 0; e_ill = 0; chk_cyc = 1'b1;
    if (op == 8'h00) begin
      len = 1; base = 2;
    end else if (op[7:6] == 2'b01 && d != 3'd6 && s != 3'd6) begin
      len = 1; base = 4; e_rd = 1; e_wr = 1;
    end else if (op[7:6] == 2'b00 && s == 3'd6 && d != 3'd6) begin
      len = 2; base = 4; e_wr = 1; chk_cyc = 1'b0;
    end else if (op == 8'hC3) begin
      len = 3; base = 5; e_load = 1;
    end else begin
      len = 1; base = 2; e_ill = 1;
    end
    a = m_pc;
    mem[a] = op;
    if (len > 1) mem[a + 16'd1] = b1;
    if (len > 2) mem[a + 16'd2] = b2;
    wsum = w0;
    wq.push_back(w0);
    if (len > 1) begin wq.push_back(w1); wsum += w1; end
    if (len > 2) begin wq.push_back(w2); wsum += w2; end
    s_inc = n_inc; s_rd = n_rd; s_wr = n_wr; s_load = n_load;
    s_done = n_done; s_ill = n_ill; s_viol = viol;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!sif.instr_done_o && cyc < 200);
    check("instr_done_seen", 64'(sif.instr_done_o), 64'd1);
    @(posedge clk);
    #1;
    if (op == 8'hC3) m_pc = {b2, b1};
    else m_pc = m_pc + 16'(len);
    if (e_rd != 0) m_regs[d] = m_regs[s];
    else if (e_wr != 0) m_regs[d] = b1;
    if (chk_cyc) check("instr_cycles", 64'(cyc), 64'(base + wsum));
    check("pc_inc_count", 64'(n_inc - s_inc), 64'(len));
    check("reg_read_count", 64'(n_rd - s_rd), 64'(e_rd));
    check("reg_write_count", 64'(n_wr - s_wr), 64'(e_wr));
    check("pc_load_count", 64'(n_load - s_load), 64'(e_load));
    check("done_count", 64'(n_done - s_done), 64'd1);
    check("illegal_count", 64'(n_ill - s_ill), 64'(e_ill));
    check("strobe_rules", 64'(viol - s_viol), 64'd0);
    check("pc_value", 64'(dp_pc), 64'(m_pc));
    for (int i = 0; i < 8; i++) begin
      pm[i*8 +: 8] = m_regs[i];
      pd[i*8 +: 8] = dp_regs[i];
    end
    check("reg_file", pd, pm);
  endtask

  initial begin
    logic [7:0] op, b1, b2;
    logic [2:0] rd3, rs3;
    int unsigned k, cyc, errs, bad, s0, s1, s2, s3;

    do_reset();
    exec(8'h00, 8'h00, 8'h00, 0, 0, 0);
    exec(8'h3E, 8'h5A, 8'h00, 0, 0, 0);
    exec(8'h0E, 8'h33, 8'h00, 1, 2, 0);
    exec(8'h41, 8'h00, 8'h00, 0, 0, 0);
    exec(8'hC3, 8'h34, 8'h12, 3, 3, 3);
    exec(8'h77, 8'h00, 8'h00, 0, 0, 0);
    exec(8'h7F, 8'h00, 8'h00, 2, 0, 0);
    exec(8'hC3, 8'hFF, 8'hFF, 0, 1, 0);
    exec(8'h16, 8'hA5, 8'h00, 1, 1, 0);

    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 4);
      rd3 = 3'($urandom_range(0, 6));
      if (rd3 == 3'd6) rd3 = 3'd7;
      rs3 = 3'($urandom_range(0, 6));
      if (rs3 == 3'd6) rs3 = 3'd7;
      b1 = 8'($urandom_range(0, 255));
      b2 = 8'($urandom_range(0, 255));
      case (k)
        0: op = 8'h00;
        1: op = {2'b01, rd3, rs3};
        2: op = {2'b00, rd3, 3'b110};
        3: op = 8'hC3;
        default: begin
          do op = 8'($urandom_range(0, 255)); while (is_legal(op));
        end
      endcase
      exec(op, b1, b2, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Memory never ready while fetching.
    do_reset();
    stall = 1'b1;
    s0 = n_inc;
`ifdef SEQ_TIMEOUT_EN
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!sif.bus_err_o && cyc < 100);
    check("timeout_cycle", 64'(cyc), 64'(TO));
    @(negedge clk);
    check("timeout_halted", 64'(sif.halted_o), 64'd1);
    check("timeout_mem_rd", 64'(sif.mem_rd_o), 64'd0);
    check("timeout_err_pulses", 64'(n_err), 64'd1);
`else
    errs = 0;
    repeat (100) begin
      @(negedge clk);
      if (sif.bus_err_o) errs++;
    end
    check("stall_mem_rd", 64'(sif.mem_rd_o), 64'd1);
    check("stall_bus_err", 64'(errs), 64'd0);
    check("stall_halted", 64'(sif.halted_o), 64'd0);
`endif
    check("stall_no_pc_inc", 64'(n_inc - s0), 64'd0);

    // HLT stays halted with no strobes.
    do_reset();
    mem[0] = 8'h76;
    wq.push_back(0);
    s0 = n_inc; s1 = n_done;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!sif.halted_o && cyc < 50);
    check("hlt_reached", 64'(sif.halted_o), 64'd1);
    check("hlt_pc_inc", 64'(n_inc - s0), 64'd1);
    check("hlt_no_done", 64'(n_done - s1), 64'd0);
    s0 = n_memrd; s1 = n_inc; s2 = n_done; s3 = viol;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (outvec() !== 64'h2) bad++;
    end
    check("hlt_hold_50", 64'(bad), 64'd0);
    check("hlt_no_memrd", 64'(n_memrd - s0 + n_inc - s1 + n_done - s2), 64'd0);
    check("hlt_strobe_rules", 64'(viol - s3), 64'd0);

    // Reset while JMP waits on its high byte.
    do_reset();
    mem[0] = 8'hC3; mem[1] = 8'h78; mem[2] = 8'h56;
    wq.push_back(0); wq.push_back(0); wq.push_back(6);
    s0 = n_inc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while ((n_inc - s0) < 2 && cyc < 50);
    check("jhi_reached", 64'(n_inc - s0), 64'd2);
    check("jhi_mem_rd", 64'(sif.mem_rd_o), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_outputs", outvec(), 64'd0);
    check("abort_reg16_sel", 64'(sif.reg16_sel_o), 64'd4);
    s1 = n_load; s2 = n_done; s3 = n_inc;
    repeat (3) @(negedge clk);
    check("abort_no_strobes", 64'(n_load - s1 + n_done - s2 + n_inc - s3), 64'd0);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
